// File: rtl/line_fill_engine.sv
// line_fill_engine: fetches one aligned 8-word line over a pipelined, in-order
// memory port and returns the words in address order as DRAM_valid beats.
// Abort (request dropped mid-fill) drains outstanding reads silently.
module line_fill_engine #(
    parameter int unsigned BEATS   = 8,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DRAM_req,
    input  logic [31:0] DRAM_req_addr,
    output logic        DRAM_valid,
    output logic [31:0] DRAM_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        proto_err
);

    localparam logic [3:0] LastCnt = 4'(BEATS);
    localparam logic [3:0] MaxOut  = 4'(MAX_OUT);

    typedef enum logic [1:0] {StIdle, StFill, StDone, StDrain} state_e;

    state_e      state_q;
    logic [31:3] base_q;
    logic [3:0]  iss_q;
    logic [3:0]  rsp_q;
    logic [3:0]  outstanding;
    logic        issue;
    logic        rsp_ok;
    logic        unused_addr_bits;

    // Low address bits are deliberately dropped: the line base is always aligned.
    assign unused_addr_bits = ^DRAM_req_addr[2:0];

    // Outstanding count uses pre-update counters, so a same-cycle issue and
    // response both count against the old value.
    assign outstanding = iss_q - rsp_q;
    assign mem_req     = (state_q == StFill) && (iss_q < LastCnt) && (outstanding < MaxOut);
    // Only the low three bits come from the counter, so the address wraps in the line.
    assign mem_addr    = {base_q, iss_q[2:0]};
    assign issue       = mem_req && mem_gnt;
    // A response is accepted only while a read is actually in flight.
    assign rsp_ok      = mem_rvalid && (outstanding != 4'd0) &&
                         ((state_q == StFill) || (state_q == StDrain));
    assign busy        = (state_q != StIdle);

    // Fill FSM with counters, line base and the registered beat output.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            base_q     <= '0;
            iss_q      <= '0;
            rsp_q      <= '0;
            DRAM_valid <= 1'b0;
            DRAM_data  <= '0;
            proto_err  <= 1'b0;
        end else begin
            DRAM_valid <= 1'b0;
            if (mem_rvalid && !rsp_ok) begin
                proto_err <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (DRAM_req) begin
                        base_q  <= DRAM_req_addr[31:3];
                        iss_q   <= '0;
                        rsp_q   <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (issue) begin
                        iss_q <= iss_q + 4'd1;
                    end
                    if (rsp_ok) begin
                        rsp_q      <= rsp_q + 4'd1;
                        DRAM_valid <= 1'b1;
                        DRAM_data  <= mem_rdata;
                    end
                    if (rsp_ok && (rsp_q + 4'd1 == LastCnt)) begin
                        state_q <= StDone;
                    end else if (!DRAM_req) begin
                        state_q <= StDrain;
                    end
                end
                StDone: begin
                    // A still-held request belongs to the line just delivered.
                    if (!DRAM_req) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (rsp_ok) begin
                        rsp_q <= rsp_q + 4'd1;
                    end
                    if ((outstanding == 4'd0) || (rsp_ok && (outstanding == 4'd1))) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// Bench for line_fill_engine: a fixed-latency in-order memory model plus
// directed/randomized fills checked against expected line contents.
`timescale 1ns/1ps
module tb_line_fill_engine;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        DRAM_req;
    logic [31:0] DRAM_req_addr;
    logic        DRAM_valid;
    logic [31:0] DRAM_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    // memory model controls and logs
    int          cyc   = 0;
    int          lat   = 2;
    int          gmode = 0;
    logic [31:0] salt  = 32'h0;
    bit          stray = 1'b0;
    int          n_iss = 0;
    int          n_rsp = 0;
    int          peak  = 0;
    int          start_neg = 0;
    logic [31:0] pend_data[$];
    int          pend_due[$];
    logic [31:0] grant_addr_q[$];
    int          grant_neg_q[$];
    logic [31:0] beat_q[$];
    int          beat_neg_q[$];
    int          resp_neg_q[$];

    line_fill_engine #(.BEATS(8), .MAX_OUT(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DRAM_req     (DRAM_req),
        .DRAM_req_addr(DRAM_req_addr),
        .DRAM_valid   (DRAM_valid),
        .DRAM_data    (DRAM_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int gn(input int k);
        return (k < grant_neg_q.size()) ? grant_neg_q[k] : -1000;
    endfunction

    function automatic int bn(input int k);
        return (k < beat_neg_q.size()) ? beat_neg_q[k] : -1000;
    endfunction

    function automatic int rn(input int k);
        return (k < resp_neg_q.size()) ? resp_neg_q[k] : -1000;
    endfunction

    // Memory: grants per gmode, returns data = addr ^ salt exactly lat edges later.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            case (gmode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = 1'($urandom_range(0, 1));
                default: mem_gnt = ((cyc % 2) == 0);
            endcase
            if (mem_req && mem_gnt) begin
                grant_addr_q.push_back(mem_addr);
                grant_neg_q.push_back(cyc);
                pend_data.push_back(mem_addr ^ salt);
                pend_due.push_back(cyc + lat);
                n_iss++;
            end
            if (n_iss - n_rsp > peak) peak = n_iss - n_rsp;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (stray) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_0001;
                stray      = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data.pop_front();
                void'(pend_due.pop_front());
                resp_neg_q.push_back(cyc);
                n_rsp++;
            end
            if (DRAM_valid) begin
                beat_q.push_back(DRAM_data);
                beat_neg_q.push_back(cyc);
            end
        end
    end

    task automatic start_fill(input logic [31:0] addr, input int l, input int g,
                              input logic [31:0] s);
        grant_addr_q.delete();
        grant_neg_q.delete();
        beat_q.delete();
        beat_neg_q.delete();
        resp_neg_q.delete();
        n_iss = 0;
        n_rsp = 0;
        peak  = 0;
        lat   = l;
        gmode = g;
        salt  = s;
        @(negedge CLK);
        #1;
        start_neg     = cyc;
        DRAM_req_addr = addr;
        DRAM_req      = 1'b1;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (beat_q.size() < n && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check({tag, "_beat_count"}, beat_q.size(), n);
    endtask

    // Expected line: word k lives at base+k and holds (base+k) ^ salt.
    task automatic check_line(input string tag, input logic [31:0] addr, input int n);
        logic [31:0] base;
        logic [31:0] a;
        base = addr & 32'hFFFF_FFF8;
        for (int k = 0; k < n; k++) begin
            a = base + k;
            check($sformatf("%s_addr%0d", tag, k),
                  (k < grant_addr_q.size()) ? grant_addr_q[k] : 32'hDEAD_BEEF, a);
            check($sformatf("%s_data%0d", tag, k),
                  (k < beat_q.size()) ? beat_q[k] : 32'hDEAD_BEEF, a ^ salt);
        end
    endtask

    task automatic release_req(input string tag, input int hold);
        int k;
        repeat (hold) begin
            @(negedge CLK);
            #1;
        end
        DRAM_req = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(DRAM_valid), 32'd0);
        check({tag, "_data"}, DRAM_data, 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        RESET         = 1'b0;
        DRAM_req      = 1'b0;
        DRAM_req_addr = '0;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        #2;
        RESET = 1'b1;

        // basic fill, data = address, zero-wait grants, latency 2
        start_fill(32'h0000_1235, 2, 0, 32'h0);
        wait_beats("basic", 8, 100);
        check("basic_first_req", 32'(gn(0) - start_neg), 32'd1);
        check("basic_consecutive", 32'(gn(7) - gn(0)), 32'd7);
        check("basic_last_beat", 32'(bn(7) - start_neg), 32'd11);
        check_line("basic", 32'h0000_1235, 8);
        check("basic_proto_err", 32'(proto_err), 32'd0);
        release_req("basic", 2);

        // outstanding limit with latency 10
        start_fill($urandom(), 10, 0, $urandom());
        wait_beats("maxout", 8, 200);
        check("maxout_peak", 32'(peak), 32'd4);
        check("maxout_first4", 32'(gn(3) - gn(0)), 32'd3);
        check("maxout_stall", 32'(gn(4) - gn(3)), 32'd8);
        check("maxout_resume", 32'(gn(4) - rn(0)), 32'd1);
        addr = DRAM_req_addr;
        check_line("maxout", addr, 8);
        release_req("maxout", 2);

        // hold request after done, then a second fill
        start_fill($urandom(), int'($urandom_range(1, 4)), 1, $urandom());
        wait_beats("hold", 8, 300);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("hold_no_req%0d", k), 32'(mem_req), 32'd0);
            check($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
        end
        check("hold_issue_count", 32'(n_iss), 32'd8);
        release_req("hold", 0);
        start_fill($urandom(), int'($urandom_range(1, 4)), 1, $urandom());
        wait_beats("second", 8, 300);
        addr = DRAM_req_addr;
        check_line("second", addr, 8);
        release_req("second", 2);

        // abort after 3 beats with 2 reads outstanding (grants on alternate cycles)
        start_fill($urandom(), 3, 2, $urandom());
        wait_beats("abort", 3, 100);
        DRAM_req = 1'b0;
        begin
            int k;
            k = 0;
            while (busy !== 1'b0 && k < 50) begin
                @(negedge CLK);
                #1;
                k++;
            end
        end
        repeat (4) begin
            @(negedge CLK);
            #1;
        end
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_issued", 32'(n_iss), 32'd5);
        check("abort_absorbed", 32'(n_rsp), 32'd5);
        check("abort_beats", beat_q.size(), 32'd3);
        check("abort_proto_err", 32'(proto_err), 32'd0);
        addr = DRAM_req_addr;
        check_line("abort", addr, 3);

        // line wrap at the top of the address space
        start_fill(32'hFFFF_FFFF, 2, 0, $urandom());
        wait_beats("wrap", 8, 100);
        check_line("wrap", 32'hFFFF_FFF8, 8);
        release_req("wrap", 2);

        // randomized fills with random grant stalls and latency
        for (int t = 0; t < 3; t++) begin
            start_fill($urandom(), int'($urandom_range(1, 6)), 1, $urandom());
            wait_beats($sformatf("rnd%0d", t), 8, 400);
            addr = DRAM_req_addr;
            check_line($sformatf("rnd%0d", t), addr, 8);
            check($sformatf("rnd%0d_peak_ok", t), 32'(peak <= 4), 32'd1);
            check($sformatf("rnd%0d_proto_err", t), 32'(proto_err), 32'd0);
            release_req($sformatf("rnd%0d", t), int'($urandom_range(1, 3)));
        end

        // asynchronous reset mid-fill, then a stray response
        start_fill($urandom(), int'($urandom_range(1, 4)), 1, $urandom());
        repeat (int'($urandom_range(3, 8))) @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check_all_zero("midreset");
        pend_data.delete();
        pend_due.delete();
        beat_q.delete();
        DRAM_req = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        stray = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            #1;
        end
        check("stray_proto_err", 32'(proto_err), 32'd1);
        check("stray_no_beat", beat_q.size(), 32'd0);
        check("stray_busy", 32'(busy), 32'd0);
        #2;
        RESET = 1'b0;
        #1;
        check("reset_clears_err", 32'(proto_err), 32'd0);
        #3;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
